mem_pattern_master: RTL and testbench

- Avalon-MM initiator driving a single-port, fixed-latency on-chip memory slave: word address, 4-bit byteenable, chipselect/write, no waitrequest.
- On a start pulse it writes an LFSR pattern over a word range, then reads the range back and compares each word.
- Reports pass/fail, error count and first failing word.
- Sits beside the Nios II system as a hardware memory self-test, controlled from a PIO/UART command block.

---
 rtl/mem_pattern_pkg.sv | 36 +++
 rtl/mem_pattern_master_lfsr.sv | 29 ++
 rtl/mem_pattern_master.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_pattern_master.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pattern_pkg.sv
// Shared types and helpers for the memory pattern master.
// LFSR step, mode decode and FSM state encoding.
package mem_pattern_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_WV     = 2'd0;
  localparam logic [1:0] MODE_WO     = 2'd1;
  localparam logic [1:0] MODE_VO     = 2'd2;
  localparam logic [1:0] MODE_WV_ALT = 2'd3;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  // Galois step, x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic logic mode_writes(input logic [1:0] m);
    mode_writes = (m == MODE_WV) || (m == MODE_WO)
               || (m == MODE_WV_ALT);
  endfunction

  function automatic logic mode_reads(input logic [1:0] m);
    mode_reads = (m == MODE_WV) || (m == MODE_VO)
              || (m == MODE_WV_ALT);
  endfunction

endpackage

// File: rtl/mem_pattern_master_lfsr.sv
// Loadable 32-bit Galois LFSR pattern source.
// A zero seed is replaced by 1 so the sequence never locks up.
module pattern_lfsr
  import mem_pattern_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_advance,
  output logic [31:0] o_value
);

  logic [31:0] r_state;

  // load has priority over advance
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= 32'h1;
    end else if (i_load) begin
      r_state <= (i_seed == 32'h0) ? 32'h1 : i_seed;
    end else if (i_advance) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_value = r_state;

endmodule

// File: rtl/mem_pattern_master.sv
// Avalon-MM memory self-test master: writes an LFSR
// pattern over a word range, reads it back, compares.
module mem_pattern_master
  import mem_pattern_pkg::*;
#(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata
);

  localparam int DLW = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ERR_W-1:0]  ERR_ONE  = 1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam logic [2:0]        RL3      = 3'(READ_LATENCY);

  state_t r_state;
  state_t w_next;

  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_left;
  logic [31:0]       r_seed;
  logic [2:0]        r_drain;
  logic [ERR_W-1:0]  r_err;
  logic [ADDR_W-1:0] r_ferr_addr;
  logic [DATA_W-1:0] r_ferr_data;
  logic              r_clken;

  logic        w_init;
  logic        w_reload;
  logic        w_step;
  logic        w_issue_rd;
  logic        w_lfsr_load;
  logic        w_lfsr_adv;
  logic        w_idle;
  logic [31:0] w_lfsr_seed;
  logic [31:0] w_lfsr;

  logic [READ_LATENCY-1:0][DLW-1:0] r_dl;
  logic [DLW-1:0]    w_dl_in;
  logic [DLW-1:0]    w_dl_out;
  logic              w_cmp_vld;
  logic [ADDR_W-1:0] w_cmp_addr;
  logic [DATA_W-1:0] w_cmp_exp;
  logic              w_mis;
  logic              w_cs;

  assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_lfsr_seed = w_idle ? seed : r_seed;

  pattern_lfsr u_lfsr (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_load    (w_lfsr_load),
    .i_seed    (w_lfsr_seed),
    .i_advance (w_lfsr_adv),
    .o_value   (w_lfsr)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next state and datapath strobes
  always_comb begin
    w_next      = r_state;
    w_init      = 1'b0;
    w_reload    = 1'b0;
    w_step      = 1'b0;
    w_issue_rd  = 1'b0;
    w_lfsr_load = 1'b0;
    w_lfsr_adv  = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_init      = 1'b1;
          w_lfsr_load = 1'b1;
          if (word_count == '0)
            w_next = S_DONE;
          else if (mode_writes(mode))
            w_next = S_WRITE;
          else
            w_next = S_READ;
        end
      end
      S_WRITE: begin
        w_step = 1'b1;
        if (r_left == CNT_ONE) begin
          if (mode_reads(r_mode)) begin
            w_next      = S_GAP;
            w_lfsr_load = 1'b1;
          end else begin
            w_next = S_DONE;
          end
        end else begin
          w_lfsr_adv = 1'b1;
        end
      end
      S_GAP: begin
        w_reload = 1'b1;
        w_next   = S_READ;
      end
      S_READ: begin
        w_step     = 1'b1;
        w_issue_rd = 1'b1;
        w_lfsr_adv = 1'b1;
        if (r_left == CNT_ONE) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain == 3'd1) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // operation parameters, address walk and drain timer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode  <= '0;
      r_base  <= '0;
      r_count <= '0;
      r_seed  <= '0;
      r_addr  <= '0;
      r_left  <= '0;
      r_drain <= '0;
      r_clken <= 1'b0;
    end else begin
      r_clken <= 1'b1;
      if (w_init) begin
        r_mode  <= mode;
        r_base  <= base_addr;
        r_count <= word_count;
        r_seed  <= seed;
        r_addr  <= base_addr;
        r_left  <= word_count;
      end else if (w_reload) begin
        r_addr <= r_base;
        r_left <= r_count;
      end else if (w_step) begin
        r_addr <= r_addr + ADDR_ONE;
        r_left <= r_left - CNT_ONE;
      end
      if (r_state == S_READ)
        r_drain <= RL3;
      else if (r_state == S_DRAIN)
        r_drain <= r_drain - 3'd1;
    end
  end

  assign w_dl_in = {w_issue_rd, r_addr, w_lfsr};

  // expected-value delay line, aligned to read latency
  if (READ_LATENCY == 1) begin : g_dl1
    always_ff @(posedge clk) begin
      if (!reset_n) r_dl <= '0;
      else          r_dl <= w_dl_in;
    end
  end else begin : g_dln
    always_ff @(posedge clk) begin
      if (!reset_n) r_dl <= '0;
      else r_dl <= {r_dl[READ_LATENCY-2:0], w_dl_in};
    end
  end

  assign w_dl_out   = r_dl[READ_LATENCY-1];
  assign w_cmp_vld  = w_dl_out[DLW-1];
  assign w_cmp_addr = w_dl_out[DATA_W +: ADDR_W];
  assign w_cmp_exp  = w_dl_out[DATA_W-1:0];
  assign w_mis      = w_cmp_vld && (m_readdata != w_cmp_exp);

  // saturating error count, first mismatch is sticky
  always_ff @(posedge clk) begin
    if (!reset_n || w_init) begin
      r_err       <= '0;
      r_ferr_addr <= '0;
      r_ferr_data <= '0;
    end else if (w_mis) begin
      if (r_err != ERR_MAX) r_err <= r_err + ERR_ONE;
      if (r_err == '0) begin
        r_ferr_addr <= w_cmp_addr;
        r_ferr_data <= m_readdata;
      end
    end
  end

  assign w_cs = (r_state == S_WRITE) || (r_state == S_READ);

  assign busy = (r_state == S_WRITE) || (r_state == S_GAP)
             || (r_state == S_READ)  || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_err == '0);
  assign error_count    = r_err;
  assign first_err_addr = r_ferr_addr;
  assign first_err_data = r_ferr_data;
  assign m_chipselect   = w_cs;
  assign m_write        = (r_state == S_WRITE);
  assign m_byteenable   = w_cs ? 4'hF : 4'h0;
  assign m_address      = w_cs ? r_addr : '0;
  assign m_writedata    = m_write ? w_lfsr : '0;
  assign m_clken        = r_clken;

endmodule

// File: tb/tb_mem_pattern_master.sv
// Bench for mem_pattern_master: 1-cycle and 3-cycle RAM
// models, directed and random runs against an LFSR model.
module tb_mem_pattern_master;

  localparam int AW = 17;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] ad;
    logic [31:0]   d;
    int            t;
  } tx_t;

  // ---------------- instance A: latency 1 ----------------
  logic          a_rst_n = 1'b0, a_start = 1'b0;
  logic [1:0]    a_mode = '0;
  logic [AW-1:0] a_base = '0;
  logic [AW:0]   a_cnt = '0;
  logic [31:0]   a_seed = '0;
  logic          a_busy, a_done, a_pass;
  logic [15:0]   a_err;
  logic [AW-1:0] a_faddr, a_addr;
  logic [31:0]   a_fdata, a_wd;
  logic [3:0]    a_be;
  logic          a_cs, a_we, a_clken;
  logic [31:0]   a_rd = '0;

  mem_pattern_master #(.ADDR_W(AW), .DATA_W(32),
    .READ_LATENCY(1), .ERR_W(16)) u_a (
    .clk(clk), .reset_n(a_rst_n), .start(a_start),
    .mode(a_mode), .base_addr(a_base), .word_count(a_cnt),
    .seed(a_seed), .busy(a_busy), .done(a_done),
    .pass(a_pass), .error_count(a_err),
    .first_err_addr(a_faddr), .first_err_data(a_fdata),
    .m_address(a_addr), .m_byteenable(a_be),
    .m_chipselect(a_cs), .m_write(a_we),
    .m_writedata(a_wd), .m_clken(a_clken),
    .m_readdata(a_rd));

  logic [31:0] a_mem [DEPTH];
  bit a_corrupt = 1'b0;

  function automatic logic [31:0] a_flip(logic [AW-1:0] ad);
    if (!a_corrupt) return 32'h0;
    if (ad == 17'd5) return 32'h1;
    if (ad == 17'd9) return 32'h100;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (a_cs && a_we) a_mem[a_addr] <= a_wd;
    if (a_cs && !a_we) a_rd <= a_mem[a_addr] ^ a_flip(a_addr);
  end

  tx_t a_q[$];
  int a_busyc = 0;
  int a_xbad = 0;
  always @(negedge clk) begin
    if (a_busy) a_busyc <= a_busyc + 1;
    if (a_cs) a_q.push_back('{a_we, a_addr, a_wd, tick});
    if (a_rst_n === 1'b1 &&
        $isunknown({a_cs, a_we, a_addr, a_wd, a_be,
                    a_busy, a_done}))
      a_xbad <= a_xbad + 1;
  end

  // ---------------- instance B: latency 3 ----------------
  logic          b_rst_n = 1'b0, b_start = 1'b0;
  logic [1:0]    b_mode = '0;
  logic [AW-1:0] b_base = '0;
  logic [AW:0]   b_cnt = '0;
  logic [31:0]   b_seed = '0;
  logic          b_busy, b_done, b_pass;
  logic [1:0]    b_err;
  logic [AW-1:0] b_faddr, b_addr;
  logic [31:0]   b_fdata, b_wd;
  logic [3:0]    b_be;
  logic          b_cs, b_we, b_clken;
  logic [31:0]   b_rd = '0, b_p0 = '0, b_p1 = '0;

  mem_pattern_master #(.ADDR_W(AW), .DATA_W(32),
    .READ_LATENCY(3), .ERR_W(2)) u_b (
    .clk(clk), .reset_n(b_rst_n), .start(b_start),
    .mode(b_mode), .base_addr(b_base), .word_count(b_cnt),
    .seed(b_seed), .busy(b_busy), .done(b_done),
    .pass(b_pass), .error_count(b_err),
    .first_err_addr(b_faddr), .first_err_data(b_fdata),
    .m_address(b_addr), .m_byteenable(b_be),
    .m_chipselect(b_cs), .m_write(b_we),
    .m_writedata(b_wd), .m_clken(b_clken),
    .m_readdata(b_rd));

  logic [31:0] b_mem [DEPTH];
  bit b_corrupt = 1'b0;

  always @(posedge clk) begin
    if (b_cs && b_we) b_mem[b_addr] <= b_wd;
    if (b_cs && !b_we)
      b_p0 <= b_mem[b_addr] ^ (b_corrupt ? 32'h80000000 : 32'h0);
    b_p1 <= b_p0;
    b_rd <= b_p1;
  end

  tx_t b_q[$];
  int b_busyc = 0;
  int b_idlec = 0;
  always @(negedge clk) begin
    if (b_busy) b_busyc <= b_busyc + 1;
    if (b_busy && !b_cs) b_idlec <= b_idlec + 1;
    if (b_cs) b_q.push_back('{b_we, b_addr, b_wd, tick});
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] lstep(logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  function automatic logic [31:0] pat(logic [31:0] sd, int k);
    logic [31:0] s;
    s = (sd == 32'h0) ? 32'h1 : sd;
    for (int i = 0; i < k; i++) s = lstep(s);
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input logic [1:0] md, input int base,
                       input int n, input logic [31:0] sd,
                       input string tag);
    int t0, q0, b0, wc, exp_busy, exp_err, bad, k, rb;
    logic [AW-1:0] ad, fa;
    logic [31:0] fd, f;
    bit rd_en, wr_en;
    wr_en = (md != 2'd2);
    rd_en = (md != 2'd1);
    q0 = a_q.size();
    b0 = a_busyc;
    a_mode = md;
    a_base = AW'(base);
    a_cnt = (AW+1)'(n);
    a_seed = sd;
    a_start = 1'b1;
    t0 = tick;
    cyc();
    a_start = 1'b0;
    wc = 0;
    while (!a_done && wc < 2 * n + 20) begin
      cyc();
      wc++;
    end
    if (n == 0) exp_busy = 0;
    else if (!rd_en) exp_busy = n;
    else if (!wr_en) exp_busy = n + 1;
    else exp_busy = 2 * n + 2;
    chk({tag, ":done"}, a_done, 1'b1);
    chk({tag, ":latency"}, wc, exp_busy);
    chk({tag, ":busy_cycles"}, a_busyc - b0, exp_busy);
    bad = 0;
    k = q0;
    if (wr_en) begin
      for (int i = 0; i < n; i++) begin
        ad = AW'(base + i);
        if (k >= a_q.size() || a_q[k].we !== 1'b1 ||
            a_q[k].ad !== ad || a_q[k].d !== pat(sd, i) ||
            a_q[k].t != t0 + 1 + i) bad++;
        k++;
      end
    end
    rb = wr_en ? n + 2 : 1;
    exp_err = 0;
    fa = '0;
    fd = '0;
    if (rd_en) begin
      for (int i = 0; i < n; i++) begin
        ad = AW'(base + i);
        if (k >= a_q.size() || a_q[k].we !== 1'b0 ||
            a_q[k].ad !== ad || a_q[k].t != t0 + rb + i) bad++;
        k++;
        f = a_flip(ad);
        if (f != 32'h0) begin
          if (exp_err == 0) begin
            fa = ad;
            fd = pat(sd, i) ^ f;
          end
          exp_err++;
        end
      end
    end
    chk({tag, ":trace"}, bad, 0);
    chk({tag, ":ntx"}, a_q.size() - q0, k - q0);
    chk({tag, ":errors"}, a_err, exp_err);
    chk({tag, ":pass"}, a_pass, exp_err == 0);
    chk({tag, ":first_addr"}, a_faddr, fa);
    chk({tag, ":first_data"}, a_fdata, fd);
    chk({tag, ":busy_low"}, a_busy, 1'b0);
  endtask

  task automatic run_b(input int base, input int n,
                       input logic [31:0] sd, input bit poke,
                       input string tag);
    int t0, q0, b0, i0, wc, bad, exp_err;
    logic [AW-1:0] ad;
    q0 = b_q.size();
    b0 = b_busyc;
    i0 = b_idlec;
    b_mode = 2'd2;
    b_base = AW'(base);
    b_cnt = (AW+1)'(n);
    b_seed = sd;
    b_start = 1'b1;
    t0 = tick;
    cyc();
    b_start = 1'b0;
    wc = 0;
    if (poke) begin
      repeat (4) cyc();
      b_mode = 2'd0;
      b_base = 17'd3;
      b_cnt = 18'd2;
      b_start = 1'b1;
      cyc();
      b_start = 1'b0;
      wc = 5;
    end
    while (!b_done && wc < 2 * n + 20) begin
      cyc();
      wc++;
    end
    chk({tag, ":done"}, b_done, 1'b1);
    chk({tag, ":busy_cycles"}, b_busyc - b0, n + 3);
    chk({tag, ":drain_cycles"}, b_idlec - i0, 3);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      ad = AW'(base + i);
      if (q0 + i >= b_q.size() || b_q[q0 + i].we !== 1'b0 ||
          b_q[q0 + i].ad !== ad || b_q[q0 + i].t != t0 + 1 + i)
        bad++;
    end
    chk({tag, ":trace"}, bad, 0);
    chk({tag, ":ntx"}, b_q.size() - q0, n);
    exp_err = b_corrupt ? ((n > 3) ? 3 : n) : 0;
    chk({tag, ":errors"}, b_err, exp_err);
    chk({tag, ":pass"}, b_pass, exp_err == 0);
    chk({tag, ":first_addr"}, b_faddr,
        b_corrupt ? AW'(base) : '0);
    chk({tag, ":first_data"}, b_fdata,
        b_corrupt ? (pat(sd, 0) ^ 32'h80000000) : 32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bb, q0;
    logic [1:0] md;
    logic [31:0] sd;

    repeat (3) cyc();
    chk("reset_outs_a",
        {a_busy, a_done, a_pass, a_err, a_faddr, a_fdata, a_addr,
         a_be, a_cs, a_we, a_wd, a_clken}, '0);
    chk("reset_outs_b",
        {b_busy, b_done, b_pass, b_err, b_cs, b_clken}, '0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    cyc();
    chk("clken_a", a_clken, 1'b1);
    chk("clken_b", b_clken, 1'b1);

    run_a(2'd0, 0, 16, 32'hACE1, "m0_clean");
    a_corrupt = 1'b1;
    run_a(2'd0, 0, 16, 32'hACE1, "m0_corrupt");
    a_corrupt = 1'b0;
    run_a(2'd0, 17'h1FFFE, 4, 32'h1357_9BDF, "wrap");
    chk("wrap:no_x", a_xbad, 0);
    run_a(2'd0, 100, 0, 32'h55, "count0");
    run_a(2'd1, 40, 1, 32'h0, "seed0");
    chk("seed0:word0", a_q[a_q.size() - 1].d, 32'h1);

    a_mode = 2'd0;
    a_base = '0;
    a_cnt = 18'd16;
    a_seed = 32'h1234;
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    repeat (6) cyc();
    chk("mid:writing", {a_cs, a_we, a_addr}, {2'b11, 17'd6});
    a_rst_n = 1'b0;
    a_start = 1'b1;
    cyc();
    chk("mid:reset_outs",
        {a_busy, a_done, a_pass, a_err, a_faddr, a_fdata, a_addr,
         a_be, a_cs, a_we, a_wd, a_clken}, '0);
    a_start = 1'b0;
    cyc();
    a_rst_n = 1'b1;
    q0 = a_q.size();
    repeat (20) cyc();
    chk("mid:quiet_bus", a_q.size() - q0, 0);
    chk("mid:idle", {a_busy, a_done}, 2'b00);
    run_a(2'd0, 0, 16, 32'h1234, "after_reset");

    for (int r = 0; r < 5; r++) begin
      case ($urandom_range(0, 2))
        0: md = 2'd0;
        1: md = 2'd1;
        default: md = 2'd3;
      endcase
      bb = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12)
                                       : $urandom_range(0, DEPTH - 1);
      sd = $urandom;
      a_corrupt = ($urandom_range(0, 1) == 1);
      run_a(md, bb, $urandom_range(1, 24), sd, $sformatf("rand%0d", r));
    end
    a_corrupt = 1'b0;

    bb = $urandom_range(0, DEPTH - 1);
    sd = $urandom;
    for (int i = 0; i < 12; i++) b_mem[AW'(bb + i)] = pat(sd, i);
    run_b(bb, 12, sd, 1'b1, "rl3_verify");
    b_corrupt = 1'b1;
    run_b(bb, 12, sd, 1'b0, "rl3_saturate");
    b_corrupt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
